// File: rtl/encode16_4_queue.sv
// encode16_4_queue: captures active-low request lines into a pending set and
// presents them one at a time, lowest index first, over a valid/ready handshake.
// Ports:
//   clk        - clock, rising edge
//   reset_n    - asynchronous active-low reset
//   Y[0:15]    - request lines, Y[i]=0 requests index i
//   enable     - 1 blocks sampling of Y, 0 allows it
//   code       - binary index of the presented request
//   out_valid  - code is valid
//   out_ready  - consumer accepts code
//   pending    - captured, not-yet-accepted requests (active-high)
//   overrun    - sticky: a request arrived on an index that was already pending
module encode16_4_queue (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [0:15]   Y,
    input  logic          enable,
    output logic [3:0]    code,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [0:15]   pending,
    output logic          overrun
);

    localparam int unsigned N  = 16;
    localparam int unsigned CW = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   code_q, code_d;
    logic            out_valid_q, out_valid_d;
    logic [0:N-1]    pending_q, pending_d;
    logic            overrun_q, overrun_d;

    logic            accept_c;
    logic [0:N-1]    set_c;
    logic [0:N-1]    clr_c;
    logic [CW-1:0]   lowest_c;

    // Pending set update: new samples set, acceptance clears; set wins on a tie.
    always_comb begin
        set_c    = '0;
        clr_c    = '0;
        accept_c = (state_q == PRESENT) && out_ready;
        if (!enable) begin
            set_c = ~Y;
        end
        if (accept_c) begin
            clr_c[code_q] = 1'b1;
        end
        pending_d = set_c | (pending_q & ~clr_c);
        // Re-request of the index being accepted on this edge is not an overrun.
        overrun_d = overrun_q | (|(set_c & pending_q & ~clr_c));
    end

    // Lowest set index of the registered pending set.
    always_comb begin
        lowest_c = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lowest_c = CW'(i);
            end
        end
    end

    // Presentation FSM: next state and registered outputs.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    code_d  = lowest_c;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (accept_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = (state_d == PRESENT);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            code_q      <= '0;
            out_valid_q <= 1'b0;
            pending_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            out_valid_q <= out_valid_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
        end
    end

    assign code      = code_q;
    assign out_valid = out_valid_q;
    assign pending   = pending_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_encode16_4_queue.sv
// Bench for encode16_4_queue: a behavioural model of the request queue is
// checked against the DUT after every edge and reset event; directed scenarios
// pin the model with hand-computed expectations, then random traffic follows.
module tb_encode16_4_queue;

    logic        clk;
    logic        reset_n;
    logic [0:15] Y;
    logic        enable;
    logic [3:0]  code;
    logic        out_valid;
    logic        out_ready;
    logic [0:15] pending;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    // Model state: the set of waiting indices, the index on offer (if any).
    bit m_pend [16];
    bit m_presenting;
    int m_code;
    bit m_overrun;

    encode16_4_queue dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .Y         (Y),
        .enable    (enable),
        .code      (code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model step and per-event comparison.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_presenting = 1'b0;
            m_code       = 0;
            m_overrun    = 1'b0;
        end else begin
            bit acc;
            bit nxt [16];
            int first;
            acc   = m_presenting && (out_ready === 1'b1);
            first = -1;
            for (int i = 15; i >= 0; i--) if (m_pend[i]) first = i;
            for (int i = 0; i < 16; i++) begin
                bit req;
                bit taken;
                req   = (enable === 1'b0) && (Y[i] === 1'b0);
                taken = acc && (m_code == i);
                if (req && m_pend[i] && !taken) m_overrun = 1'b1;
                nxt[i] = req || (m_pend[i] && !taken);
            end
            if (!m_presenting) begin
                if (first >= 0) begin
                    m_code       = first;
                    m_presenting = 1'b1;
                end
            end else if (acc) begin
                m_presenting = 1'b0;
            end
            foreach (nxt[i]) m_pend[i] = nxt[i];
        end
        #1;
        begin
            logic [0:15] exp_p;
            for (int i = 0; i < 16; i++) exp_p[i] = m_pend[i];
            check("model_pending",   32'(pending),   32'(exp_p));
            check("model_out_valid", 32'(out_valid), 32'(m_presenting));
            check("model_overrun",   32'(overrun),   32'(m_overrun));
            if (m_presenting) check("model_code", 32'(code), 32'(m_code));
        end
    end

    // Advance one edge and settle past the compare process.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [0:15] req1(input int a);
        logic [0:15] v;
        v    = '1;
        v[a] = 1'b0;
        return v;
    endfunction

    initial begin
        reset_n   = 1'b0;
        Y         = '1;
        enable    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("reset_pending", 32'(pending),   32'h0);
        check("reset_valid",   32'(out_valid), 32'h0);
        check("reset_code",    32'(code),      32'h0);
        check("reset_overrun", 32'(overrun),   32'h0);
        reset_n = 1'b1;
        tick();
        check("idle_valid", 32'(out_valid), 32'h0);

        // Single request on index 5.
        out_ready = 1'b1;
        Y = req1(5);
        tick();
        check("single_pend5", 32'(pending[5]), 32'h1);
        check("single_valid_k", 32'(out_valid), 32'h0);
        Y = '1;
        tick();
        check("single_code", 32'(code), 32'h5);
        check("single_valid", 32'(out_valid), 32'h1);
        tick();
        check("single_pend_clear", 32'(pending), 32'h0);
        check("single_valid_off", 32'(out_valid), 32'h0);

        // Priority with stall, lower index arrives while presenting.
        out_ready = 1'b0;
        Y = '1; Y[3] = 1'b0; Y[12] = 1'b0;
        tick();
        Y = '1;
        tick();
        check("prio_code3", 32'(code), 32'h3);
        Y = req1(1);
        tick();
        check("prio_hold3a", 32'(code), 32'h3);
        Y = '1;
        tick();
        check("prio_hold3b", 32'(code), 32'h3);
        check("prio_pend", 32'(pending), 32'h5008);
        out_ready = 1'b1;
        tick();
        check("prio_gap", 32'(out_valid), 32'h0);
        tick();
        check("prio_code1", 32'(code), 32'h1);
        tick();
        tick();
        check("prio_code12", 32'(code), 32'hC);
        check("prio_valid12", 32'(out_valid), 32'h1);
        tick();

        // Enable masking, then all sixteen at once.
        out_ready = 1'b0;
        enable = 1'b1;
        Y = '0;
        for (int n = 0; n < 4; n++) begin
            tick();
            check("mask_pending", 32'(pending), 32'h0);
            check("mask_valid", 32'(out_valid), 32'h0);
        end
        enable = 1'b0;
        tick();
        check("all_pending", 32'(pending), 32'hFFFF);
        enable = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            tick();
            check("all_code", 32'(code), 32'(c));
            check("all_valid", 32'(out_valid), 32'h1);
            tick();
        end
        check("all_drained", 32'(pending), 32'h0);
        enable = 1'b0;
        Y = '1;

        // Set wins on acceptance, then a true overrun.
        out_ready = 1'b0;
        Y = req1(7);
        tick();
        Y = '1;
        tick();
        check("sw_code7", 32'(code), 32'h7);
        out_ready = 1'b1;
        Y = req1(7);
        tick();
        check("sw_pend7", 32'(pending[7]), 32'h1);
        check("sw_no_overrun", 32'(overrun), 32'h0);
        out_ready = 1'b0;
        Y = '1;
        tick();
        check("sw_again7", 32'(code), 32'h7);
        check("sw_again_valid", 32'(out_valid), 32'h1);
        Y = req1(7);
        tick();
        check("overrun_set", 32'(overrun), 32'h1);
        Y = '1;
        tick();
        check("overrun_sticky", 32'(overrun), 32'h1);

        // Asynchronous reset mid-presentation.
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        Y = '1; Y[0] = 1'b0; Y[15] = 1'b0;
        tick();
        Y = '1;
        tick();
        check("ar_pending", 32'(pending), 32'h8001);
        check("ar_valid", 32'(out_valid), 32'h1);
        reset_n = 1'b0;
        #2;
        check("ar_pend0", 32'(pending), 32'h0);
        check("ar_valid0", 32'(out_valid), 32'h0);
        check("ar_code0", 32'(code), 32'h0);
        check("ar_ovr0", 32'(overrun), 32'h0);
        #2;
        reset_n = 1'b1;
        tick();
        tick();
        check("ar_after_valid", 32'(out_valid), 32'h0);
        check("ar_after_pend", 32'(pending), 32'h0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            logic [0:15] v;
            v = '1;
            for (int i = 0; i < 16; i++) if ($urandom_range(0, 15) == 0) v[i] = 1'b0;
            Y         = v;
            enable    = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                #3;
                reset_n = 1'b1;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
